// File: rtl/palm_locator_if.sv
// Pixel-stream / palm-report bundle between segmentation and palm_locator.
// PALM_HEIGHT_OVERRIDE_EN adds the test_mode/test_height override pair.
interface palm_locator_if #(
    parameter int CW = 8
);
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_obj;
    logic          palm_valid;
    logic          palm_found;
    logic          frame_done;
    logic [CW-1:0] start_r;
    logic [CW-1:0] start_c;
    logic [CW-1:0] end_r;
    logic [CW-1:0] end_c;
    logic [CW-1:0] palm_width;
    logic [CW-1:0] palm_height;
`ifdef PALM_HEIGHT_OVERRIDE_EN
    logic          test_mode;
    logic [CW-1:0] test_height;

    modport master (
        output pix_valid, pix_sof, pix_obj, test_mode, test_height,
        input  palm_valid, palm_found, frame_done,
        input  start_r, start_c, end_r, end_c, palm_width, palm_height
    );

    modport slave (
        input  pix_valid, pix_sof, pix_obj, test_mode, test_height,
        output palm_valid, palm_found, frame_done,
        output start_r, start_c, end_r, end_c, palm_width, palm_height
    );
`else
    modport master (
        output pix_valid, pix_sof, pix_obj,
        input  palm_valid, palm_found, frame_done,
        input  start_r, start_c, end_r, end_c, palm_width, palm_height
    );

    modport slave (
        input  pix_valid, pix_sof, pix_obj,
        output palm_valid, palm_found, frame_done,
        output start_r, start_c, end_r, end_c, palm_width, palm_height
    );
`endif
endinterface

// File: rtl/palm_locator.sv
// Finds the first horizontal object run per frame wider than WIDTH_THR and reports it.
// Build option: PALM_HEIGHT_OVERRIDE_EN lets test_mode/test_height replace the derived height.
module palm_locator #(
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int CW        = 8,
    parameter int WIDTH_THR = 17
) (
    input  logic           clk,
    input  logic           rst,
    palm_locator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FOUND = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_R = CW'(IMG_H - 1);
    localparam logic [CW-1:0] THR    = CW'(WIDTH_THR);

    state_t        state_q, state_d;
    logic          st_idle, st_scan;

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          run_open_q, run_open_d;
    logic [CW-1:0] run_start_q, run_start_d;
    logic [CW-1:0] last_c_q, last_c_d;

    logic          palm_valid_q, palm_valid_d;
    logic          palm_found_q, palm_found_d;
    logic          frame_done_q, frame_done_d;
    logic [CW-1:0] palm_row_q, palm_row_d;
    logic [CW-1:0] start_c_q, start_c_d;
    logic [CW-1:0] end_c_q, end_c_d;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] height_q, height_d;

    logic          sof_take, pix_take, track, open_eff, last_pix;
    logic          close_run, accept;
    logic [CW-1:0] cur_r, cur_c, cls_start, cls_last, w;
    logic [CW:0]   h_sum;
    logic [CW-1:0] h_calc, h_sel;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (pix_take) begin
            if (last_pix)      state_d = IDLE;
            else if (accept)   state_d = FOUND;
            else if (sof_take) state_d = SCAN;
        end
    end

    // ---------------- FSM: state decode ----------------
    always_comb begin
        st_idle = (state_q == IDLE);
        st_scan = (state_q == SCAN);
    end

    // ---------------- Pixel datapath ----------------
    always_comb begin
        sof_take  = bus.pix_valid && bus.pix_sof;
        pix_take  = bus.pix_valid && (sof_take || !st_idle);
        // A sof pixel is processed as (0,0) with no run carried over from the aborted frame.
        cur_r     = sof_take ? '0 : row_q;
        cur_c     = sof_take ? '0 : col_q;
        open_eff  = run_open_q && !sof_take;
        track     = pix_take && (st_scan || sof_take);
        last_pix  = (cur_r == LAST_R) && (cur_c == LAST_C);

        close_run = 1'b0;
        cls_start = run_start_q;
        cls_last  = last_c_q;
        if (track) begin
            if (bus.pix_obj) begin
                if (cur_c == LAST_C) begin
                    close_run = 1'b1;
                    cls_start = open_eff ? run_start_q : cur_c;
                    cls_last  = cur_c;
                end
            end else if (open_eff) begin
                close_run = 1'b1;
            end
        end

        w      = cls_last - cls_start;
        accept = close_run && (w > THR);

        h_sum  = {1'b0, w} + {2'b00, w[CW-1:1]};
        h_calc = h_sum[CW] ? {CW{1'b1}} : h_sum[CW-1:0];
`ifdef PALM_HEIGHT_OVERRIDE_EN
        h_sel  = bus.test_mode ? bus.test_height : h_calc;
`else
        h_sel  = h_calc;
`endif
    end

    // Counters and run tracking
    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        run_open_d  = run_open_q;
        run_start_d = run_start_q;
        last_c_d    = last_c_q;

        if (pix_take) begin
            if (last_pix) begin
                row_d = '0;
                col_d = '0;
            end else if (cur_c == LAST_C) begin
                row_d = cur_r + 1'b1;
                col_d = '0;
            end else begin
                row_d = cur_r;
                col_d = cur_c + 1'b1;
            end
        end

        if (sof_take) run_open_d = 1'b0;

        if (track) begin
            if (bus.pix_obj && !close_run) begin
                if (!open_eff) begin
                    run_open_d  = 1'b1;
                    run_start_d = cur_c;
                end
                last_c_d = cur_c;
            end
            if (close_run) run_open_d = 1'b0;
        end

        if (pix_take && last_pix) run_open_d = 1'b0;
    end

    // Report registers
    always_comb begin
        palm_valid_d = accept;
        frame_done_d = pix_take && last_pix;
        palm_found_d = palm_found_q;
        palm_row_d   = palm_row_q;
        start_c_d    = start_c_q;
        end_c_d      = end_c_q;
        width_d      = width_q;
        height_d     = height_q;

        if (sof_take) palm_found_d = 1'b0;
        if (accept) begin
            palm_found_d = 1'b1;
            palm_row_d   = cur_r;
            start_c_d    = cls_start;
            end_c_d      = cls_last;
            width_d      = w;
            height_d     = h_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            last_c_q     <= '0;
            palm_valid_q <= 1'b0;
            palm_found_q <= 1'b0;
            frame_done_q <= 1'b0;
            palm_row_q   <= '0;
            start_c_q    <= '0;
            end_c_q      <= '0;
            width_q      <= '0;
            height_q     <= '0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            run_open_q   <= run_open_d;
            run_start_q  <= run_start_d;
            last_c_q     <= last_c_d;
            palm_valid_q <= palm_valid_d;
            palm_found_q <= palm_found_d;
            frame_done_q <= frame_done_d;
            palm_row_q   <= palm_row_d;
            start_c_q    <= start_c_d;
            end_c_q      <= end_c_d;
            width_q      <= width_d;
            height_q     <= height_d;
        end
    end

    assign bus.palm_valid  = palm_valid_q;
    assign bus.palm_found  = palm_found_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.start_r     = palm_row_q;
    assign bus.end_r       = palm_row_q;
    assign bus.start_c     = start_c_q;
    assign bus.end_c       = end_c_q;
    assign bus.palm_width  = width_q;
    assign bus.palm_height = height_q;

endmodule

// File: doc/palm_locator.md
# palm_locator

Streaming palm locator for the gesture-recognition pipeline, placed directly after skin/object segmentation. It consumes a raster-order binary object stream with frame sync and pixel-valid qualification. It finds the first horizontal object run in a frame whose width exceeds a programmable threshold, then reports that run's row/column bounds, its width, and a derived palm height. It re-arms on every frame, so downstream finger/gesture stages get one palm report per frame.

## Interface
- IMG_W, 160, pixels per row
- IMG_H, 120, rows per frame
- CW, 8, width of all coordinate/size outputs; must satisfy 2^CW ≥ max(IMG_W, IMG_H)
- WIDTH_THR, 17, run accepted when (end_c − start_c) > WIDTH_THR
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pixel qualifier; all other pix_* inputs ignored when low
- pix_sof  in  1  first pixel of frame (row 0, col 0), qualified by pix_valid
- pix_obj  in  1  segmented object (hand) pixel
- palm_valid  out  1  one-cycle pulse: palm detected, outputs updated
- palm_found  out  1  level: palm detected in current frame
- frame_done  out  1  one-cycle pulse after last pixel of frame
- start_r, start_c, end_r, end_c  out  CW  palm run bounds (start_r == end_r)
- palm_width  out  CW  end_c − start_c
- palm_height  out  CW  derived palm height

## Operation
- FSM states: IDLE (wait for sof), SCAN, FOUND.
- IDLE: pixels without pix_sof are ignored. A valid pixel with pix_sof enters SCAN, and that pixel is processed as (0,0).
- pix_sof in SCAN or FOUND: aborts the frame, restarts counters at (0,0), discards any open run, clears palm_found, and enters SCAN. Coordinate/size outputs keep their last values.
- Counters: col runs 0..IMG_W−1. At IMG_W−1, col wraps to 0 and row increments. They advance only on valid pixels and hold while pix_valid is low.
- Run tracking in SCAN: an obj pixel with no open run opens a run at the current col. Each obj pixel records last_c. A non-obj pixel closes the open run. An obj pixel at col IMG_W−1 closes the run with that pixel included. Runs never span rows.
- On close: w = last_c − run_start_c, computed in CW bits.
  - If w > WIDTH_THR: register start_r = end_r = current row, start_c, end_c = last_c, palm_width = w, and palm_height. Pulse palm_valid, set palm_found, and enter FOUND.
  - Otherwise: discard the run and continue.
- palm_height = w + (w >> 1), computed in CW+1 bits and saturated to 2^CW−1.
- FOUND: ignores pix_obj; counters keep running.
- Last pixel of frame (row IMG_H−1, col IMG_W−1) in SCAN or FOUND: pulse frame_done and go to IDLE. palm_found holds until the next sof.
- A single-pixel run has w = 0 and is never accepted.

## Timing
- Reset: all outputs 0; state IDLE; counters 0; no open run.
- rst asserted mid-frame wins over everything else in that cycle. The block then needs a new pix_sof.
- Latency: palm_valid, registered outputs, and frame_done all assert on the cycle after the terminating pixel is sampled.
- If the closing pixel is the frame's last pixel, palm_valid and frame_done pulse in the same cycle.
- Gaps in pix_valid do not close a run.
- Back-to-back frames: sof on the cycle after the last pixel is accepted, because IDLE takes it immediately.

## Configuration
- PALM_HEIGHT_OVERRIDE_EN defined: adds inputs test_mode (1 bit) and test_height (CW bits). At run acceptance, if test_mode = 1, palm_height = test_height (sampled that cycle); otherwise the computed value is used.
- PALM_HEIGHT_OVERRIDE_EN undefined: those ports are absent and palm_height is always computed.

## Test plan
- Reset: assert rst for 2 cycles with random inputs -> every output 0; no palm_valid until after a sof.
- Defaults, row 10 obj cols 40..63, rest 0 -> cycle after pixel (10,64): palm_valid = 1, start = (10,40), end = (10,63), palm_width 23, palm_height 34, palm_found stays 1, frame_done at frame end.
- Row 3 cols 5..22 (w = 17, rejected), row 20 cols 0..29 -> only one palm_valid: (20,0)-(20,29), width 29, height 43.
- Row 119 cols 100..159, pix_valid toggling every other cycle -> width 59, height 88; palm_valid and frame_done in the same cycle.
- Empty frame -> frame_done only, palm_found 0. Sof injected at (50,7) mid-run -> run discarded, counters restart at (0,0).
- PALM_HEIGHT_OVERRIDE_EN, test_mode = 1, test_height = 50, scenario 2 -> height 50. With test_mode = 0 -> height 34.
